// File: rtl/io_bus_pkg.sv
// Shared types and constants for the CPU-side IO bus initiator and bus decode.
package io_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } io_init_state_t;

  localparam logic [31:0] DEV_UART     = 32'h0000_0000;
  localparam logic [31:0] DEV_GPOUT    = 32'h0000_0004;
  localparam logic [31:0] DEV_CLK_FREQ = 32'h0000_1002;
  localparam logic [31:0] HDMI_BASE    = 32'h1000_0000;

  localparam int unsigned TIMEOUT_DEFAULT = 1_000_000;

endpackage

// File: rtl/io_bus_initiator.sv
// Turns one in/out request into a single held IO bus beat and returns one
// response, aborting with a timeout flag if the device never handshakes.
module io_bus_initiator
  import io_bus_pkg::*;
#(
  parameter int unsigned TimeoutCycles = TIMEOUT_DEFAULT,
  parameter int unsigned CntWidth      = (TimeoutCycles < 1) ? 1 : $clog2(TimeoutCycles + 1)
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [31:0] i_req_dev_id,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_timeout,
  output logic [31:0] o_dev_id,
  output logic        if_bus_dout_valid,
  input  logic        if_bus_dout_ready,
  output logic [31:0] if_bus_dout_bits,
  input  logic        if_bus_din_valid,
  output logic        if_bus_din_ready,
  input  logic [31:0] if_bus_din_bits
);

  io_init_state_t      state_q;
  logic                req_ready_q;
  logic                resp_valid_q;
  logic [31:0]         rdata_q;
  logic                timeout_q;
  logic [31:0]         dev_id_q;
  logic                dout_valid_q;
  logic [31:0]         dout_bits_q;
  logic                din_ready_q;
  logic [CntWidth-1:0] cnt_q;
  logic [CntWidth-1:0] cnt_d;
  logic                expired;

  // A zero TimeoutCycles disables expiry entirely.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    expired = 1'b0;
    if (TimeoutCycles != 0) begin
      expired = (cnt_q == CntWidth'(TimeoutCycles - 1));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      timeout_q    <= 1'b0;
      dev_id_q     <= '0;
      dout_valid_q <= 1'b0;
      dout_bits_q  <= '0;
      din_ready_q  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Bus strobes start next cycle so decode sees a settled device id.
          if (i_req_valid) begin
            dev_id_q    <= i_req_dev_id;
            dout_bits_q <= i_req_wdata;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            if (i_req_write) begin
              dout_valid_q <= 1'b1;
              state_q      <= WRITE;
            end else begin
              din_ready_q <= 1'b1;
              state_q     <= READ;
            end
          end
        end
        WRITE: begin
          if (if_bus_dout_ready || expired) begin
            dout_valid_q <= 1'b0;
            rdata_q      <= '0;
            timeout_q    <= !if_bus_dout_ready;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        READ: begin
          if (if_bus_din_valid || expired) begin
            din_ready_q  <= 1'b0;
            rdata_q      <= if_bus_din_valid ? if_bus_din_bits : 32'h0;
            timeout_q    <= !if_bus_din_valid;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP: begin
          if (i_resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_req_ready       = req_ready_q;
  assign o_resp_valid      = resp_valid_q;
  assign o_resp_rdata      = rdata_q;
  assign o_resp_timeout    = timeout_q;
  assign o_dev_id          = dev_id_q;
  assign if_bus_dout_valid = dout_valid_q;
  assign if_bus_dout_bits  = dout_bits_q;
  assign if_bus_din_ready  = din_ready_q;

endmodule

// File: tb/tb_io_bus_initiator.sv
// Directed bench for io_bus_initiator with a 16-cycle timeout.
module tb_io_bus_initiator;
  import io_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_dev_id = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_timeout;
  logic [31:0] dev_id;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic [31:0] dout_bits;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [31:0] din_bits = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  io_bus_initiator #(.TimeoutCycles(16)) dut (
    .i_clk            (clk),
    .i_rst            (rst_n),
    .i_req_valid      (req_valid),
    .o_req_ready      (req_ready),
    .i_req_write      (req_write),
    .i_req_dev_id     (req_dev_id),
    .i_req_wdata      (req_wdata),
    .o_resp_valid     (resp_valid),
    .i_resp_ready     (resp_ready),
    .o_resp_rdata     (resp_rdata),
    .o_resp_timeout   (resp_timeout),
    .o_dev_id         (dev_id),
    .if_bus_dout_valid(dout_valid),
    .if_bus_dout_ready(dout_ready),
    .if_bus_dout_bits (dout_bits),
    .if_bus_din_valid (din_valid),
    .if_bus_din_ready (din_ready),
    .if_bus_din_bits  (din_bits)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    check({tag, ".resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, ".rdata"}, resp_rdata, 32'd0);
    check({tag, ".timeout"}, 32'(resp_timeout), 32'd0);
    check({tag, ".dev_id"}, dev_id, 32'd0);
    check({tag, ".dout_valid"}, 32'(dout_valid), 32'd0);
    check({tag, ".dout_bits"}, dout_bits, 32'd0);
    check({tag, ".din_ready"}, 32'(din_ready), 32'd0);
  endtask

  task automatic issue(input logic wr, input logic [31:0] id, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_write  = wr;
    req_dev_id = id;
    req_wdata  = wd;
    tick();
    req_valid  = 1'b0;
  endtask

  task automatic take_resp(input string tag);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, ".idle_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, ".idle_resp_valid"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    check_reset_values("rst");
    rst_n = 1'b1;
    tick();

    // Out to GPOUT, bus ready three cycles after valid
    check("wr.pre_valid", 32'(dout_valid), 32'd0);
    issue(1'b1, DEV_GPOUT, 32'h0000_00A5);
    check("wr.req_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("wr.valid", 32'(dout_valid), 32'd1);
      check("wr.bits", dout_bits, 32'h0000_00A5);
      check("wr.dev_id", dev_id, 32'h4);
      check("wr.din_ready", 32'(din_ready), 32'd0);
      check("wr.no_resp", 32'(resp_valid), 32'd0);
      if (i < 2) tick();
    end
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    check("wr.resp_valid", 32'(resp_valid), 32'd1);
    check("wr.rdata", resp_rdata, 32'd0);
    check("wr.timeout", 32'(resp_timeout), 32'd0);
    check("wr.valid_drop", 32'(dout_valid), 32'd0);
    check("wr.dev_id_hold", dev_id, 32'h4);
    take_resp("wr");
    check("wr.dev_id_kept", dev_id, 32'h4);

    // In from CLK_FREQ, data on the first READ cycle
    issue(1'b0, DEV_CLK_FREQ, 32'hDEAD_BEEF);
    check("rd.din_ready", 32'(din_ready), 32'd1);
    check("rd.dout_valid", 32'(dout_valid), 32'd0);
    check("rd.dev_id", dev_id, 32'h1002);
    din_valid = 1'b1;
    din_bits  = 32'd15_000_000;
    tick();
    din_valid = 1'b0;
    din_bits  = '0;
    check("rd.resp_valid", 32'(resp_valid), 32'd1);
    check("rd.rdata", resp_rdata, 32'h00E4_E1C0);
    check("rd.timeout", 32'(resp_timeout), 32'd0);
    check("rd.one_beat", 32'(din_ready), 32'd0);
    take_resp("rd");

    // Timeout on unmapped device
    issue(1'b1, 32'h0000_2000, 32'h1234_5678);
    for (int i = 0; i < 15; i++) tick();
    check("to.still_waiting", 32'(dout_valid), 32'd1);
    check("to.no_resp_yet", 32'(resp_valid), 32'd0);
    tick();
    check("to.resp_valid", 32'(resp_valid), 32'd1);
    check("to.timeout", 32'(resp_timeout), 32'd1);
    check("to.rdata", resp_rdata, 32'd0);
    check("to.valid_drop", 32'(dout_valid), 32'd0);
    take_resp("to");

    // Handshake coincident with expiry wins
    issue(1'b1, DEV_UART, 32'h0000_0041);
    for (int i = 0; i < 15; i++) tick();
    check("co.no_resp_yet", 32'(resp_valid), 32'd0);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    check("co.resp_valid", 32'(resp_valid), 32'd1);
    check("co.timeout", 32'(resp_timeout), 32'd0);

    // Backpressure: response held, new request ignored
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_dev_id = HDMI_BASE;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp.resp_valid", 32'(resp_valid), 32'd1);
      check("bp.timeout", 32'(resp_timeout), 32'd0);
      check("bp.rdata", resp_rdata, 32'd0);
      check("bp.req_ready", 32'(req_ready), 32'd0);
      check("bp.din_ready", 32'(din_ready), 32'd0);
      check("bp.dev_id", dev_id, DEV_UART);
    end
    req_valid  = 1'b0;
    take_resp("bp");
    check("bp.no_new_txn", 32'(din_ready), 32'd0);

    // Asynchronous reset during READ
    issue(1'b0, DEV_CLK_FREQ, 32'h0);
    check("ar.in_read", 32'(din_ready), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("ar");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("ar.no_resp", 32'(resp_valid), 32'd0);
    issue(1'b1, DEV_UART, 32'h0000_005A);
    check("ar.wr_bits", dout_bits, 32'h0000_005A);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    check("ar.resp_valid", 32'(resp_valid), 32'd1);
    check("ar.timeout", 32'(resp_timeout), 32'd0);
    take_resp("ar");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/io_bus_initiator.md
Name: io_bus_initiator

Overview:
- CPU-side initiator for the IO bus: turns one `in`/`out` request from the pipeline into a held bus transaction, then returns a single response.
- Drives device id, write data/valid and read ready towards the IO bus decoder; waits for that side's handshake.
- Adds a per-transaction timeout so accesses to unmapped or stalled devices cannot hang the core.
- Sits between the execute/memory stage and the IO bus; exactly one outstanding transaction.

Parameters:
- TimeoutCycles, 1_000_000, bus-wait cycles before abort; 0 disables the timeout.
- CntWidth, $clog2(TimeoutCycles+1) (min 1), width of the wait counter; derived, do not override.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-low
- i_req_valid  in  1  request present
- o_req_ready  out  1  initiator can accept a request
- i_req_write  in  1  1=out (write), 0=in (read)
- i_req_dev_id  in  32  target device id
- i_req_wdata  in  32  write data (ignored for in)
- o_resp_valid  out  1  response present
- i_resp_ready  in  1  pipeline accepts response
- o_resp_rdata  out  32  read data (0 for out or timeout)
- o_resp_timeout  out  1  transaction aborted by timeout
- o_dev_id  out  32  device id to bus, registered
- if_bus_dout  Decoupled.sender  32  write channel to bus (valid/bits out, ready in)
- if_bus_din  Decoupled.receiver  32  read channel from bus (valid/bits in, ready out)

Behaviour:
- Reset (i_rst=0, async): state=IDLE, o_req_ready=1, o_resp_valid=0, o_resp_rdata=0, o_resp_timeout=0, o_dev_id=0, if_bus_dout.valid=0, if_bus_dout.bits=0, if_bus_din.ready=0, counter=0.
- States: IDLE, WRITE, READ, RESP.
- IDLE:
  - o_req_ready=1.
  - On i_req_valid: register dev_id, wdata, write flag; clear counter; go to WRITE (write=1) or READ (write=0).
  - The bus never sees a request in the same cycle it is accepted. This lets the bus decoder's combinational select see a stable id.
- WRITE:
  - if_bus_dout.valid=1, bits=latched wdata, o_dev_id=latched id, if_bus_din.ready=0.
  - On if_bus_dout.ready=1: rdata=0, timeout=0; go to RESP.
- READ:
  - if_bus_din.ready=1, if_bus_dout.valid=0.
  - On if_bus_din.valid=1: capture bits into rdata, timeout=0; go to RESP.
- Timeout (WRITE/READ):
  - Counter increments each cycle without handshake.
  - When counter==TimeoutCycles-1 and no handshake that cycle: rdata=0, timeout=1; go to RESP.
  - Handshake in the same cycle as expiry wins: normal completion, timeout=0.
  - TimeoutCycles=0: never time out.
- Bus-side valid/ready are dropped in the cycle after the handshake (state leaves WRITE/READ). Each transaction is exactly one bus beat.
- RESP:
  - o_resp_valid=1; rdata and timeout held stable.
  - On i_resp_ready: go to IDLE.
  - o_req_ready=0 here, so there is no request/response overlap.
  - Minimum latency: accept at cycle 0, bus beat at cycle ≥1, o_resp_valid from the cycle after the beat.
- o_dev_id holds the last id after completion (not cleared), so there are no glitches into bus decode.
- Reset mid-operation: immediate return to the reset values; the in-flight request is lost and no response is produced.
- Read data is taken full 32-bit, with no masking. Devices already zero-extend.

Decomposition:
- Shared package io_bus_pkg:
  - state enum io_init_state_t {IDLE, WRITE, READ, RESP};
  - device-id constants DEV_UART=0x0000, DEV_GPOUT=0x0004, DEV_CLK_FREQ=0x1002, HDMI_BASE=0x1000_0000;
  - TIMEOUT_DEFAULT.
- Single module; the timeout counter is inline. A sub-module is not warranted.

Test Plan:
- Out to 0x0004 with wdata 0x000000A5; bus asserts if_bus_dout.ready 3 cycles after valid. Expect:
  - valid rises the cycle after acceptance; bits=0xA5 and o_dev_id=0x4 held throughout;
  - o_resp_valid one cycle after the beat, rdata=0, timeout=0.
- In from 0x1002; bus drives valid with bits=15_000_000 on the first READ cycle. Expect o_resp_rdata=0x00E4E1C0, timeout=0, exactly one bus beat.
- TimeoutCycles=16, out to unmapped 0x2000, ready held 0. Expect o_resp_valid after 16 WRITE cycles, timeout=1, rdata=0, valid deasserted.
- Expiry coincident with handshake (ready=1 in the 16th cycle). Expect timeout=0, normal completion.
- Response backpressure: i_resp_ready=0 for 5 cycles. Expect response held stable, o_req_ready=0, and a new i_req_valid ignored until the response is taken.
- Assert i_rst=0 during READ. Expect all outputs at reset values immediately (async); after release, a new request completes normally.
